// File: rtl/cr_ram_burst_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr_ram_burst_pkg
// Purpose  : Shared types and helpers for the RAM read-burst engine.
//            - state_e      : FSM state encoding (idle / burst)
//            - desc_len()   : extract the length field of a descriptor
//            - desc_addr()  : extract the start-address field of a descriptor
//            - desc_t       : descriptor layout at the default widths
//            - LEN_ZERO     : length value that marks a discard-only descriptor
// Revision : 1.0 - initial release
// ============================================================================
package cr_ram_burst_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   localparam int C_DEF_AW = 16;
   localparam int C_DEF_LW = 8;

   // Length is the upper field; address occupies the low AW bits.
   typedef struct packed {
      logic [C_DEF_LW-1:0] len;
      logic [C_DEF_AW-1:0] addr;
   } desc_t;

   localparam int LEN_ZERO = 0;

   // Descriptors are passed zero-extended to 64 bits so one function serves
   // every AW/LW combination; callers cast the result back to their width.
   function automatic logic [31:0] desc_len(input logic [63:0] desc,
                                            input int unsigned aw,
                                            input int unsigned lw);
      logic [63:0] v;
      v = (desc >> aw) & ((64'd1 << lw) - 64'd1);
      return v[31:0];
   endfunction

   function automatic logic [31:0] desc_addr(input logic [63:0] desc,
                                             input int unsigned aw);
      logic [63:0] v;
      v = desc & ((64'd1 << aw) - 64'd1);
      return v[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cr_ram_burst_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_ram_burst_engine_if
// Purpose  : Descriptor-FIFO and RAM read-request bundle of the burst engine.
//            master : engine side (pops FIFO, drives RAM read request)
//            slave  : environment side (FIFO + RAM model/controller)
// Signals  : fifo_data, fifo_empty, fifo_rd, ram_ready, ram_read, ram_addr,
//            busy, ram_last (only when CR_RAM_BURST_LAST_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
interface cr_ram_burst_engine_if #(
   parameter int AW = 16,
   parameter int LW = 8
);
   localparam int DW = AW + LW;

   logic [DW-1:0] fifo_data;
   logic          fifo_empty;
   logic          fifo_rd;
   logic          ram_ready;
   logic          ram_read;
   logic [AW-1:0] ram_addr;
   logic          busy;
`ifdef CR_RAM_BURST_LAST_EN
   logic          ram_last;
`endif

   modport master (
      input  fifo_data, fifo_empty, ram_ready,
`ifdef CR_RAM_BURST_LAST_EN
      output ram_last,
`endif
      output fifo_rd, ram_read, ram_addr, busy
   );

   modport slave (
      output fifo_data, fifo_empty, ram_ready,
`ifdef CR_RAM_BURST_LAST_EN
      input  ram_last,
`endif
      input  fifo_rd, ram_read, ram_addr, busy
   );

endinterface
`default_nettype wire

// File: rtl/cr_ram_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : cr_ram_burst_engine
// Purpose  : Pops {length, start address} descriptors from a FWFT FIFO and
//            issues one RAM read per word with an incrementing (wrapping)
//            address. Back-to-back descriptors chain with no idle cycle;
//            zero-length descriptors are popped and discarded.
// Ports    : clk      - clock
//            reset_n  - asynchronous active-low reset
//            bif      - cr_ram_burst_engine_if.master (FIFO + RAM request)
// Options  : CR_RAM_BURST_LAST_EN - adds registered ram_last output, high
//            while the final word of a burst is being requested.
// Revision : 1.0 - initial release
// ============================================================================
module cr_ram_burst_engine
   import cr_ram_burst_pkg::*;
#(
   parameter int AW = 16,
   parameter int LW = 8
) (
   input  wire                     clk,
   input  wire                     reset_n,
   cr_ram_burst_engine_if.master   bif
);

   localparam int DW = AW + LW;

   localparam logic [0:0] c_ST_IDLE  = ST_IDLE;
   localparam logic [0:0] c_ST_BURST = ST_BURST;
   localparam logic [LW-1:0] c_LEN_ZERO = LW'(LEN_ZERO);
   localparam logic [LW-1:0] c_LEN_ONE  = LW'(1);

   logic [0:0]    r_state;
   logic          r_ram_read;
   logic [AW-1:0] r_ram_addr;
   logic [LW-1:0] r_remaining;
   logic          r_busy;

   logic [0:0]    w_nxt_state;
   logic          w_nxt_read;
   logic [AW-1:0] w_nxt_addr;
   logic [LW-1:0] w_nxt_rem;
   logic          w_nxt_busy;

   logic [LW-1:0] w_head_len;
   logic [AW-1:0] w_head_addr;
   logic          w_head_nz;
   logic          w_issue;
   logic          w_last_issue;
   logic          w_pop;

   assign w_head_len  = LW'(desc_len(64'(bif.fifo_data), AW, LW));
   assign w_head_addr = AW'(desc_addr(64'(bif.fifo_data), AW));
   assign w_head_nz   = (w_head_len != c_LEN_ZERO);

   // ram_read is always 1 in BURST, so an issue is simply read & ready.
   assign w_issue      = (r_state == c_ST_BURST) & r_ram_read & bif.ram_ready;
   assign w_last_issue = w_issue & (r_remaining == c_LEN_ONE);

   // The FIFO may only be touched when idle or on the final word of a burst,
   // which is what lets the next descriptor load with zero bubble.
   assign w_pop = ~bif.fifo_empty & ((r_state == c_ST_IDLE) | w_last_issue);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_read  = r_ram_read;
      w_nxt_addr  = r_ram_addr;
      w_nxt_rem   = r_remaining;
      w_nxt_busy  = r_busy;
      case (r_state)
         c_ST_IDLE: begin
            if (w_pop && w_head_nz) begin
               w_nxt_state = c_ST_BURST;
               w_nxt_read  = 1'b1;
               w_nxt_addr  = w_head_addr;
               w_nxt_rem   = w_head_len;
               w_nxt_busy  = 1'b1;
            end
         end
         c_ST_BURST: begin
            if (w_last_issue) begin
               if (w_pop && w_head_nz) begin
                  w_nxt_addr = w_head_addr;
                  w_nxt_rem  = w_head_len;
               end else begin
                  // Covers both an empty FIFO and a popped zero-length head.
                  w_nxt_state = c_ST_IDLE;
                  w_nxt_read  = 1'b0;
                  w_nxt_busy  = 1'b0;
                  w_nxt_addr  = r_ram_addr + AW'(1);
                  w_nxt_rem   = c_LEN_ZERO;
               end
            end else if (w_issue) begin
               w_nxt_addr = r_ram_addr + AW'(1);
               w_nxt_rem  = r_remaining - c_LEN_ONE;
            end
         end
         default: begin
            w_nxt_state = c_ST_IDLE;
            w_nxt_read  = 1'b0;
            w_nxt_busy  = 1'b0;
            w_nxt_rem   = c_LEN_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= c_ST_IDLE;
         r_ram_read  <= 1'b0;
         r_ram_addr  <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_ram_read  <= w_nxt_read;
         r_ram_addr  <= w_nxt_addr;
         r_remaining <= w_nxt_rem;
         r_busy      <= w_nxt_busy;
      end
   end

   assign bif.fifo_rd  = w_pop;
   assign bif.ram_read = r_ram_read;
   assign bif.ram_addr = r_ram_addr;
   assign bif.busy     = r_busy;

`ifdef CR_RAM_BURST_LAST_EN
   logic r_ram_last;

   // Derived from next-state values so it lines up with ram_read/ram_addr
   // and naturally holds while the final word is stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ram_last <= 1'b0;
      end else begin
         r_ram_last <= w_nxt_read & (w_nxt_rem == c_LEN_ONE);
      end
   end

   assign bif.ram_last = r_ram_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_ram_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_ram_burst_engine
// Purpose  : Directed self-checking bench for cr_ram_burst_engine with a
//            queue-based FWFT descriptor FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_ram_burst_engine;

   localparam int AW = 16;
   localparam int LW = 8;
   localparam int DW = AW + LW;

   logic clk;
   logic reset_n;

   int errors;
   int checks;
   int issued;
   logic last_rd;
   logic [DW-1:0] q [$];

   cr_ram_burst_engine_if #(.AW(AW), .LW(LW)) bif ();

   cr_ram_burst_engine #(.AW(AW), .LW(LW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bif     (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic refresh();
      bif.fifo_empty = (q.size() == 0);
      bif.fifo_data  = (q.size() == 0) ? '0 : q[0];
   endtask

   task automatic push(input logic [LW-1:0] len, input logic [AW-1:0] addr);
      q.push_back({len, addr});
      refresh();
   endtask

   // One clock: sample the combinational pop request and issue mid-cycle,
   // apply the FIFO pop at the edge, return 1 time unit after the edge.
   task automatic tick();
      @(negedge clk);
      last_rd = bif.fifo_rd;
      if (bif.ram_read && bif.ram_ready) issued++;
      checks++;
      if (bif.fifo_rd && bif.fifo_empty) begin
         errors++;
         $display("FAIL rd_when_empty fifo_rd=%0b fifo_empty=%0b", bif.fifo_rd, bif.fifo_empty);
      end
      @(posedge clk);
      #1;
      if (last_rd && q.size() != 0) void'(q.pop_front());
      refresh();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bif.ram_read, bif.ram_addr, bif.busy, bif.fifo_rd} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got read=%0b addr=%h busy=%0b rd=%0b exp 0/0000/0/0",
                  bif.ram_read, bif.ram_addr, bif.busy, bif.fifo_rd);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checks++;
      if (bif.ram_read !== 1'b0 || bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got read=%0b busy=%0b exp 0/0", bif.ram_read, bif.busy);
      end
   endtask

   task automatic test_single_burst();
      logic [15:0] ea [3] = '{16'h0010, 16'h0011, 16'h0012};
      logic        er [3] = '{1'b1, 1'b0, 1'b0};
      issued = 0;
      push(8'd3, 16'h0010);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (last_rd !== er[i] || bif.ram_read !== 1'b1 || bif.ram_addr !== ea[i] || bif.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_w%0d got rd=%0b read=%0b addr=%h busy=%0b exp rd=%0b read=1 addr=%h busy=1",
                     i, last_rd, bif.ram_read, bif.ram_addr, bif.busy, er[i], ea[i]);
         end
      end
      tick();
      checks++;
      if (bif.ram_read !== 1'b0 || bif.busy !== 1'b0 || issued != 3) begin
         errors++;
         $display("FAIL single_end got read=%0b busy=%0b issued=%0d exp 0/0/3", bif.ram_read, bif.busy, issued);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ea [4] = '{16'h0100, 16'h0101, 16'h0200, 16'h0201};
      logic        er [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      issued = 0;
      push(8'd2, 16'h0100);
      push(8'd2, 16'h0200);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (last_rd !== er[i] || bif.ram_read !== 1'b1 || bif.ram_addr !== ea[i]) begin
            errors++;
            $display("FAIL b2b_w%0d got rd=%0b read=%0b addr=%h exp rd=%0b read=1 addr=%h",
                     i, last_rd, bif.ram_read, bif.ram_addr, er[i], ea[i]);
         end
      end
      tick();
      checks++;
      if (bif.ram_read !== 1'b0 || bif.busy !== 1'b0 || issued != 4) begin
         errors++;
         $display("FAIL b2b_end got read=%0b busy=%0b issued=%0d exp 0/0/4", bif.ram_read, bif.busy, issued);
      end
   endtask

   task automatic test_stall();
      issued = 0;
      push(8'd4, 16'h0020);
      tick();
      tick();
      bif.ram_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bif.ram_read !== 1'b1 || bif.ram_addr !== 16'h0021) begin
            errors++;
            $display("FAIL stall_hold%0d got read=%0b addr=%h exp 1/0021", i, bif.ram_read, bif.ram_addr);
         end
      end
      bif.ram_ready = 1'b1;
      tick();
      checks++;
      if (bif.ram_addr !== 16'h0022) begin
         errors++;
         $display("FAIL stall_resume got addr=%h exp 0022", bif.ram_addr);
      end
      tick();
      tick();
      checks++;
      if (bif.ram_read !== 1'b0 || issued != 4) begin
         errors++;
         $display("FAIL stall_total got read=%0b issued=%0d exp 0/4", bif.ram_read, issued);
      end
   endtask

   task automatic test_zero_len_wrap();
      logic [15:0] ea [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
      issued = 0;
      push(8'd0, 16'h1234);
      push(8'd3, 16'hFFFE);
      tick();
      checks++;
      if (last_rd !== 1'b1 || bif.ram_read !== 1'b0 || bif.busy !== 1'b0 || q.size() != 1) begin
         errors++;
         $display("FAIL zero_discard got rd=%0b read=%0b busy=%0b qsize=%0d exp 1/0/0/1",
                  last_rd, bif.ram_read, bif.busy, q.size());
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bif.ram_read !== 1'b1 || bif.ram_addr !== ea[i]) begin
            errors++;
            $display("FAIL wrap_w%0d got read=%0b addr=%h exp 1/%h", i, bif.ram_read, bif.ram_addr, ea[i]);
         end
      end
      tick();
      checks++;
      if (bif.ram_read !== 1'b0 || issued != 3 || bif.fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_end got read=%0b issued=%0d empty=%0b exp 0/3/1", bif.ram_read, issued, bif.fifo_empty);
      end
   endtask

   task automatic test_reset_mid_burst();
      issued = 0;
      push(8'd10, 16'h0040);
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (bif.ram_addr !== 16'h0044 || issued != 4) begin
         errors++;
         $display("FAIL pre_reset got addr=%h issued=%0d exp 0044/4", bif.ram_addr, issued);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bif.ram_read !== 1'b0 || bif.ram_addr !== 16'h0000 || bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got read=%0b addr=%h busy=%0b exp 0/0000/0",
                  bif.ram_read, bif.ram_addr, bif.busy);
      end
      @(negedge clk);
      reset_n = 1'b1;
      issued = 0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (bif.ram_read !== 1'b0 || bif.busy !== 1'b0 || issued != 0) begin
         errors++;
         $display("FAIL post_reset_idle got read=%0b busy=%0b issued=%0d exp 0/0/0",
                  bif.ram_read, bif.busy, issued);
      end
   endtask

`ifdef CR_RAM_BURST_LAST_EN
   task automatic test_last();
      logic [15:0] ea [3] = '{16'h0050, 16'h0051, 16'h0052};
      logic        el [3] = '{1'b0, 1'b0, 1'b1};
      push(8'd3, 16'h0050);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bif.ram_addr !== ea[i] || bif.ram_last !== el[i]) begin
            errors++;
            $display("FAIL last_w%0d got addr=%h last=%0b exp %h/%0b", i, bif.ram_addr, bif.ram_last, ea[i], el[i]);
         end
      end
      bif.ram_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bif.ram_addr !== 16'h0052 || bif.ram_last !== 1'b1) begin
            errors++;
            $display("FAIL last_stall%0d got addr=%h last=%0b exp 0052/1", i, bif.ram_addr, bif.ram_last);
         end
      end
      bif.ram_ready = 1'b1;
      tick();
      checks++;
      if (bif.ram_read !== 1'b0 || bif.ram_last !== 1'b0) begin
         errors++;
         $display("FAIL last_end got read=%0b last=%0b exp 0/0", bif.ram_read, bif.ram_last);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      issued = 0;
      last_rd = 1'b0;
      reset_n = 1'b0;
      bif.ram_ready = 1'b1;
      refresh();
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_stall();
      test_zero_len_wrap();
      test_reset_mid_burst();
`ifdef CR_RAM_BURST_LAST_EN
      test_last();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/cr_ram_burst_engine.md
Name: cr_ram_burst_engine

Overview:
- Parametrised RAM read-burst generator, successor to the single-RAM imitator engine.
- Pops descriptors {length, start address} from a first-word-fall-through FIFO.
- Issues one RAM read strobe per word with an incrementing address; honours a RAM-side ready/stall.
- Chains back-to-back descriptors with no idle cycle; sits between the credit FIFO and the RAM model/controller.

Parameters:
- AW, 16, RAM address width; address wraps modulo 2^AW.
- LW, 8, burst length field width; legal lengths 0..2^LW-1.
- DW, AW+LW, descriptor width (derived; must not be overridden).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fifo_data  in  DW  descriptor: [DW-1:AW] = length, [AW-1:0] = start address; valid while fifo_empty=0
- fifo_empty  in  1  1 = no descriptor available
- fifo_rd  out  1  1 = descriptor consumed this cycle (combinational)
- ram_ready  in  1  1 = RAM accepts the read this cycle
- ram_read  out  1  1 = read request valid (registered)
- ram_addr  out  AW  read address (registered)
- busy  out  1  1 = burst in progress (registered)

Behaviour:
- Reset (reset_n=0, asynchronous) forces state IDLE, ram_read=0, ram_addr=0, busy=0, remaining=0.
- A reset mid-burst abandons the remainder; no partially consumed descriptor is restored.
- Release is synchronous to clk.
- States:
  - IDLE: fifo_rd = ~fifo_empty. On pop with length>0: next cycle BURST, ram_read=1, ram_addr=start, remaining=length, busy=1. On pop with length=0: descriptor discarded, stay IDLE, no read issued.
  - BURST: a word issues on ram_read & ram_ready. Each issue: ram_addr+1 (wraps 2^AW-1 -> 0), remaining-1.
- Stall: while ram_ready=0, ram_read, ram_addr and remaining hold.
- Latency: descriptor visible in cycle N -> first ram_read in cycle N+1.
- Last word issued (remaining=1 & ram_ready):
  - If fifo_empty=0 and the head length>0: fifo_rd=1 in the same cycle; next cycle ram_addr=new start; ram_read stays 1 (zero bubble).
  - If the head length=0: it is popped and discarded; return to IDLE.
  - Otherwise: IDLE next cycle, ram_read=0, busy=0.
- fifo_rd never asserts in BURST except on the last-word issue cycle.
- fifo_rd never asserts when fifo_empty=1.
- Max length 2^LW-1; remaining counter is LW bits.
- Over a sequence of nonzero descriptors, the count of ram_read & ram_ready cycles equals the sum of their lengths.

Optional Feature:
- Macro CR_RAM_BURST_LAST_EN.
- Defined: adds output ram_last (1 bit, registered, reset 0), equal to 1 while ram_read=1 and remaining=1. It holds through stalls.
- Undefined: port absent; no extra logic.

Decomposition:
- Package cr_ram_burst_pkg holds:
  - state enum {ST_IDLE, ST_BURST};
  - a descriptor packed-struct typedef generator (length/address field-extraction functions taking AW/LW);
  - constant LEN_ZERO.
- No sub-module: the FSM, address counter and remaining counter stay in one module.

Test Plan:
- Single burst: AW=16, LW=8, push {len=3, addr=0x0010}, ram_ready=1 -> fifo_rd one cycle; ram_addr 0x0010, 0x0011, 0x0012 on consecutive cycles; then ram_read=0, busy=0.
- Back-to-back: push {2, 0x0100} and {2, 0x0200} -> addresses 0x0100, 0x0101, 0x0200, 0x0201 in four consecutive ram_read cycles, no gap.
- Stall: {4, 0x0020}, ram_ready low for 3 cycles after the second word -> ram_addr holds 0x0021 during the stall; total of 4 issued words.
- Zero length and wrap: push {0, 0x1234} then {3, 0xFFFE} -> first descriptor popped with no read; addresses 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-burst: {10, 0x0040}, drop reset_n after 4 words -> ram_read=0, ram_addr=0, busy=0 immediately (asynchronous). After release with an empty FIFO, no reads.
- With CR_RAM_BURST_LAST_EN: {3, 0x0050}, stall on the last word -> ram_last=1 only while ram_addr=0x0052, held through the stall.
